// File: rtl/rgb_sample_filter.sv
`default_nettype none
// ============================================================================
// Module   : rgb_sample_filter
// Function : Decimates the colour-sensor R/G/B registers, box-averages each
//            window and republishes only moves larger than the hysteresis band.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_sample_filter #(
    parameter int SAMPLE_DIV = 500_000,
    parameter int AVG_LOG2   = 3,
    parameter int HYST       = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] data_r_in,
    input  logic [7:0] data_g_in,
    input  logic [7:0] data_b_in,
    output logic [7:0] data_r_out,
    output logic [7:0] data_g_out,
    output logic [7:0] data_b_out,
    output logic       avg_valid,
    output logic       color_changed
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int ACC_W = 8 + AVG_LOG2;

    localparam logic [DIV_W-1:0]    c_DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [AVG_LOG2-1:0] c_LAST_SMP = '1;
    localparam logic [7:0]          c_HYST     = 8'(HYST);

    localparam logic [0:0] c_ST_ACC = 1'b0;
    localparam logic [0:0] c_ST_PUB = 1'b1;

    // Channel index 2 = red, 1 = green, 0 = blue throughout.
    logic [2:0][7:0]       w_din;
    logic [2:0][7:0]       w_avg;
    logic [2:0][7:0]       w_diff;
    logic [2:0]            w_over;
    logic                  w_tick;
    logic                  w_upd;

    logic [DIV_W-1:0]      r_div_cnt_q,       w_div_cnt_d;
    logic [AVG_LOG2-1:0]   r_scnt_q,          w_scnt_d;
    logic [2:0][ACC_W-1:0] r_acc_q,           w_acc_d;
    logic [2:0][7:0]       r_out_q,           w_out_d;
    logic [0:0]            r_state_q,         w_state_d;
    logic                  r_first_done_q,    w_first_done_d;
    logic                  r_avg_valid_q,     w_avg_valid_d;
    logic                  r_color_changed_q, w_color_changed_d;

    assign w_din  = {data_r_in, data_g_in, data_b_in};
    assign w_tick = (r_div_cnt_q == c_DIV_MAX);

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        assign w_avg[gi]  = r_acc_q[gi][ACC_W-1:AVG_LOG2];
        assign w_diff[gi] = (w_avg[gi] >= r_out_q[gi]) ? (w_avg[gi] - r_out_q[gi])
                                                       : (r_out_q[gi] - w_avg[gi]);
        assign w_over[gi] = (w_diff[gi] > c_HYST);
    end

    assign w_upd = !r_first_done_q || (|w_over);

    always_comb begin
        w_div_cnt_d       = w_tick ? '0 : r_div_cnt_q + 1'b1;
        w_scnt_d          = r_scnt_q;
        w_acc_d           = r_acc_q;
        w_out_d           = r_out_q;
        w_state_d         = r_state_q;
        w_first_done_d    = r_first_done_q;
        w_avg_valid_d     = 1'b0;
        w_color_changed_d = 1'b0;

        case (r_state_q)
            c_ST_ACC: begin
                if (w_tick) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        w_acc_d[ch] = r_acc_q[ch] + {{AVG_LOG2{1'b0}}, w_din[ch]};
                    end
                    w_scnt_d = r_scnt_q + 1'b1;
                    if (r_scnt_q == c_LAST_SMP) begin
                        w_state_d = c_ST_PUB;
                    end
                end
            end
            c_ST_PUB: begin
                w_avg_valid_d = 1'b1;
                if (w_upd) begin
                    w_out_d           = w_avg;
                    w_color_changed_d = 1'b1;
                    w_first_done_d    = 1'b1;
                end
                w_acc_d   = '0;
                w_scnt_d  = '0;
                w_state_d = c_ST_ACC;
            end
            default: begin
                w_state_d = c_ST_ACC;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div_cnt_q       <= '0;
            r_scnt_q          <= '0;
            r_acc_q           <= '0;
            r_out_q           <= '0;
            r_state_q         <= c_ST_ACC;
            r_first_done_q    <= 1'b0;
            r_avg_valid_q     <= 1'b0;
            r_color_changed_q <= 1'b0;
        end else begin
            r_div_cnt_q       <= w_div_cnt_d;
            r_scnt_q          <= w_scnt_d;
            r_acc_q           <= w_acc_d;
            r_out_q           <= w_out_d;
            r_state_q         <= w_state_d;
            r_first_done_q    <= w_first_done_d;
            r_avg_valid_q     <= w_avg_valid_d;
            r_color_changed_q <= w_color_changed_d;
        end
    end

    assign data_r_out    = r_out_q[2];
    assign data_g_out    = r_out_q[1];
    assign data_b_out    = r_out_q[0];
    assign avg_valid     = r_avg_valid_q;
    assign color_changed = r_color_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_sample_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_sample_filter
// Function : Self-checking bench for rgb_sample_filter with a sample-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_sample_filter;

    localparam int SAMPLE_DIV = 4;
    localparam int AVG_LOG2   = 2;
    localparam int HYST       = 4;
    localparam int NSAMP      = 1 << AVG_LOG2;
    localparam int WIN        = SAMPLE_DIV * NSAMP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
    logic [7:0] r_out, g_out, b_out;
    logic       av, cc;

    int errors = 0;
    int checks = 0;

    rgb_sample_filter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AVG_LOG2   (AVG_LOG2),
        .HYST       (HYST)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .data_r_in     (r_in),
        .data_g_in     (g_in),
        .data_b_in     (b_in),
        .data_r_out    (r_out),
        .data_g_out    (g_out),
        .data_b_out    (b_out),
        .avg_valid     (av),
        .color_changed (cc)
    );

    always #5 clk = ~clk;

    // Reference model: edges since release, a list of tick samples per window,
    // and the published colour. Channel 0 = r, 1 = g, 2 = b.
    int         cyc;
    int         samples[$][3];
    int         win_sum[3];
    bit         pend;
    bit         first_done;
    logic [7:0] m_out[3];
    logic       m_av, m_cc;
    logic       prev_av;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            samples.delete();
            pend = 0;
            first_done = 0;
            for (int ch = 0; ch < 3; ch++) m_out[ch] = 8'd0;
            m_av = 0;
            m_cc = 0;
        end else begin
            int  avg;
            int  d;
            bit  upd;
            cyc++;
            m_av = 0;
            m_cc = 0;
            if (pend) begin
                pend = 0;
                m_av = 1;
                upd  = !first_done;
                for (int ch = 0; ch < 3; ch++) begin
                    avg = win_sum[ch] / NSAMP;
                    d   = avg - int'(m_out[ch]);
                    if (d < 0) d = -d;
                    if (d > HYST) upd = 1;
                end
                if (upd) begin
                    for (int ch = 0; ch < 3; ch++) m_out[ch] = 8'(win_sum[ch] / NSAMP);
                    m_cc = 1;
                    first_done = 1;
                end
            end
            if (cyc % SAMPLE_DIV == 0) begin
                samples.push_back('{int'(r_in), int'(g_in), int'(b_in)});
                if (samples.size() == NSAMP) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        win_sum[ch] = 0;
                        foreach (samples[s]) win_sum[ch] += samples[s][ch];
                    end
                    samples.delete();
                    pend = 1;
                end
            end
        end
    end

    // Advance to the negedge just after a publish (new window starts there).
    task automatic sync_to_publish();
        int n = 0;
        @(negedge clk);
        while ((cyc % WIN) != 1 && n < 2 * WIN) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((cyc % WIN) != 1) begin
            errors++;
            $display("FAIL sync_to_publish cyc=%0d never aligned", cyc);
        end
        prev_av = av;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_in = 8'd100; g_in = 8'd50; b_in = 8'd200;
        repeat (3) @(negedge clk);
        checks++;
        if ({r_out, g_out, b_out, av, cc} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state got=%h required=0", {r_out, g_out, b_out, av, cc});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_publish();
        int early = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k < 17 && (av || cc)) early++;
            if (k == 17) begin
                checks++;
                if ({av, cc, r_out, g_out, b_out} !== {1'b1, 1'b1, 8'd100, 8'd50, 8'd200}) begin
                    errors++;
                    $display("FAIL first_publish got av=%b cc=%b %0d/%0d/%0d required 1 1 100/50/200",
                             av, cc, r_out, g_out, b_out);
                end
            end
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL first_publish_early got %0d early pulses required 0", early);
        end
        prev_av = av;
    endtask

    task automatic test_steady();
        int n_av = 0, n_cc = 0, n_bad = 0;
        for (int k = 0; k < 2 * WIN; k++) begin
            @(negedge clk);
            n_av += int'(av);
            n_cc += int'(cc);
            if ({r_out, g_out, b_out} !== {8'd100, 8'd50, 8'd200}) n_bad++;
        end
        checks++;
        if (n_av != 2 || n_cc != 0 || n_bad != 0) begin
            errors++;
            $display("FAIL steady got av=%0d cc=%0d badout=%0d required 2 0 0", n_av, n_cc, n_bad);
        end
        prev_av = av;
    endtask

    task automatic test_hysteresis();
        sync_to_publish();
        r_in = 8'd104;
        repeat (WIN) @(negedge clk);
        checks++;
        if ({av, cc, r_out} !== {1'b1, 1'b0, 8'd100}) begin
            errors++;
            $display("FAIL hyst_equal got av=%b cc=%b r=%0d required 1 0 100", av, cc, r_out);
        end
        r_in = 8'd105;
        repeat (WIN) @(negedge clk);
        checks++;
        if ({av, cc, r_out, g_out, b_out} !== {1'b1, 1'b1, 8'd105, 8'd50, 8'd200}) begin
            errors++;
            $display("FAIL hyst_over got av=%b cc=%b %0d/%0d/%0d required 1 1 105/50/200",
                     av, cc, r_out, g_out, b_out);
        end
        prev_av = av;
    endtask

    task automatic test_alternate_and_max();
        sync_to_publish();
        for (int k = 0; k < WIN; k++) begin
            g_in = (((cyc + 1) / SAMPLE_DIV) % 2 == 0) ? 8'd0 : 8'd255;
            @(negedge clk);
        end
        checks++;
        if ({av, cc, r_out, g_out, b_out} !== {1'b1, 1'b1, 8'd105, 8'd127, 8'd200}) begin
            errors++;
            $display("FAIL alternate got av=%b cc=%b %0d/%0d/%0d required 1 1 105/127/200",
                     av, cc, r_out, g_out, b_out);
        end
        r_in = 8'd255; g_in = 8'd255; b_in = 8'd255;
        repeat (WIN) @(negedge clk);
        checks++;
        if ({av, cc, r_out, g_out, b_out} !== {1'b1, 1'b1, 8'd255, 8'd255, 8'd255}) begin
            errors++;
            $display("FAIL full_scale got av=%b cc=%b %0d/%0d/%0d required 1 1 255/255/255",
                     av, cc, r_out, g_out, b_out);
        end
        prev_av = av;
    endtask

    task automatic test_reset_mid_window();
        int early = 0;
        sync_to_publish();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r_out, g_out, b_out, av, cc} !== 26'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h required=0", {r_out, g_out, b_out, av, cc});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k < 17 && (av || cc)) early++;
        end
        checks++;
        if (early != 0 || {av, cc, r_out, g_out, b_out} !== {1'b1, 1'b1, 8'd255, 8'd255, 8'd255}) begin
            errors++;
            $display("FAIL reset_republish got early=%0d av=%b cc=%b %0d/%0d/%0d required 0 1 1 255/255/255",
                     early, av, cc, r_out, g_out, b_out);
        end
        prev_av = av;
    endtask

    task automatic test_random();
        int base[3];
        for (int ch = 0; ch < 3; ch++) base[ch] = $urandom_range(0, 243);
        for (int k = 0; k < 40 * WIN; k++) begin
            if ($urandom_range(0, 63) == 0)
                for (int ch = 0; ch < 3; ch++) base[ch] = $urandom_range(0, 243);
            r_in = 8'(base[0] + $urandom_range(0, 12));
            g_in = 8'(base[1] + $urandom_range(0, 12));
            b_in = 8'(base[2] + $urandom_range(0, 12));
            @(negedge clk);
            checks++;
            if ({r_out, g_out, b_out, av, cc} !== {m_out[0], m_out[1], m_out[2], m_av, m_cc}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got %0d/%0d/%0d av=%b cc=%b required %0d/%0d/%0d av=%b cc=%b",
                         cyc, r_out, g_out, b_out, av, cc, m_out[0], m_out[1], m_out[2], m_av, m_cc);
            end
            checks++;
            if ((av && prev_av) || (cc && !av)) begin
                errors++;
                $display("FAIL pulse_rules cyc=%0d got av=%b prev_av=%b cc=%b required single av, cc only with av",
                         cyc, av, prev_av, cc);
            end
            prev_av = av;
        end
    endtask

    initial begin
        prev_av = 1'b0;
        test_reset();
        test_first_publish();
        test_steady();
        test_hysteresis();
        test_alternate_and_max();
        test_reset_mid_window();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
